seq_shifter: RTL
================

Name: seq_shifter

Overview:
- Parametrised, multi-cycle shift/rotate engine; next generation of the 4-bit load/shift-left/shift-right register.
- Adds generic WIDTH, variable shift amount, rotate, arithmetic shift and serial in/out.
- Uses a start/busy/done handshake and shifts one bit per enabled clock.
- Sits between the counter/display datapath and a controlling FSM that issues shift commands.

Parameters:
- WIDTH, 8, data register width (≥2).
- SHAMT_W, 3, width of shift-amount input; maximum shift is 2**SHAMT_W-1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  clock enable; low freezes all state (stall)
- start  in  1  command strobe, sampled only in IDLE with en=1
- mode  in  3  operation: 0 LOAD, 1 SHL, 2 SHR logical, 3 ROL, 4 ROR, 5 ASR, 6/7 treated as LOAD
- amt  in  SHAMT_W  number of single-bit steps
- din  in  WIDTH  operand loaded at start
- ser_in  in  1  fill bit for SHL (into LSB) and SHR (into MSB)
- dout  out  WIDTH  shift register contents; final result valid while done=1
- ser_out  out  1  registered copy of the last bit shifted/rotated out
- busy  out  1  high in SHIFT and DONE
- done  out  1  one-cycle pulse in DONE

Behaviour:
- Reset (async): state=IDLE, dout=0, ser_out=0, cnt=0, busy=0, done=0, latched mode=LOAD.
- All transitions occur on the clk rising edge with en=1. With en=0, state, dout, cnt and ser_out hold, and done stays high if already in DONE.
- IDLE:
  - start=1: dout<=din, mode and amt latched, cnt<=amt.
  - Next state DONE if mode is LOAD/6/7 or amt=0, else SHIFT.
  - start=0: hold.
- SHIFT: each enabled edge applies one step of the latched mode, cnt<=cnt-1, ser_out<=the departing bit.
  - SHL/ROL: ser_out<=dout[WIDTH-1].
  - SHR/ROR/ASR: ser_out<=dout[0].
  - When cnt=1 at the edge, that final step executes and next state is DONE.
- Step definitions:
  - SHL: {dout[W-2:0],ser_in}
  - SHR: {ser_in,dout[W-1:1]}
  - ROL: {dout[W-2:0],dout[W-1]}
  - ROR: {dout[0],dout[W-1:1]}
  - ASR: {dout[W-1],dout[W-1:1]}
- DONE: done=1 for exactly one enabled cycle, then IDLE. A start seen in DONE is ignored.
- Latency: start edge → done asserted after amt+1 enabled edges (LOAD or amt=0: 1 edge).
- start while busy: ignored, no queuing.
- din, mode, amt and ser_in are not sampled during SHIFT except ser_in, which is sampled at every step edge.
- amt ≥ WIDTH is legal:
  - SHL/SHR fully flush with ser_in.
  - Rotates wrap modulo WIDTH.
  - ASR saturates to the sign fill.
- ser_out is unchanged by LOAD.
- Reset mid-operation aborts immediately to the reset values above. No done pulse.

Decomposition:
- Shared package seq_shifter_pkg holds:
  - mode localparams MODE_LOAD=0, MODE_SHL=1, MODE_SHR=2, MODE_ROL=3, MODE_ROR=4, MODE_ASR=5
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE
- One combinational sub-module, shift_step_unit (WIDTH): inputs data, mode, ser_in; outputs next data and out_bit. It keeps the step logic separately testable.
- The FSM, counter and registers stay in seq_shifter.

Test Plan:
All cases use WIDTH=8, SHAMT_W=3.
1. Hold reset, then release → dout=0x00, busy=0, done=0, ser_out=0. Pulse start with mode=LOAD, din=0xA5 → done one edge later, dout=0xA5.
2. SHL, din=0x81, amt=3, ser_in=0 → busy for 4 edges, done on 4th, dout=0x08, ser_out=0. Repeat with ser_in=1 → dout=0x0F.
3. ROR, din=0x3C, amt=4 → dout=0xC3, ser_out=1. ASR, din=0x90, amt=2 → dout=0xE4, ser_out=0.
4. ROL, din=0x01, amt=7 → dout=0x80. Then amt=0 with mode SHL → done after 1 edge, dout=din.
5. SHR, din=0xF0, amt=4, with en low for 3 cycles mid-shift and start re-pulsed while busy → dout=0x0F. done asserts 3 cycles later than normal. The second start is ignored.
6. Assert reset asynchronously (between edges) during SHIFT → outputs clear immediately, with no done pulse. A subsequent LOAD 0x5A works normally.

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the sequential shift/rotate engine:
// operation codes, FSM state encoding and a mode classifier.
package seq_shifter_pkg;

    localparam logic [2:0] MODE_LOAD = 3'd0;
    localparam logic [2:0] MODE_SHL  = 3'd1;
    localparam logic [2:0] MODE_SHR  = 3'd2;
    localparam logic [2:0] MODE_ROL  = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;
    localparam logic [2:0] MODE_ASR  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Codes 0, 6 and 7 all behave as a plain load with no stepping.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/seq_shifter_step.sv
// Combinational single-bit step of the shift engine: computes the
// next register value and the bit leaving the register for one mode.
module shift_step_unit
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] next_data,
    output logic             out_bit
);

    // One step of the selected operation; load codes pass data through.
    always_comb begin
        next_data = data;
        out_bit   = data[0];
        case (mode)
            MODE_SHL: begin
                next_data = {data[WIDTH-2:0], ser_in};
                out_bit   = data[WIDTH-1];
            end
            MODE_SHR: begin
                next_data = {ser_in, data[WIDTH-1:1]};
                out_bit   = data[0];
            end
            MODE_ROL: begin
                next_data = {data[WIDTH-2:0], data[WIDTH-1]};
                out_bit   = data[WIDTH-1];
            end
            MODE_ROR: begin
                next_data = {data[0], data[WIDTH-1:1]};
                out_bit   = data[0];
            end
            MODE_ASR: begin
                next_data = {data[WIDTH-1], data[WIDTH-1:1]};
                out_bit   = data[0];
            end
            default: begin
                next_data = data;
                out_bit   = data[0];
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate engine with start/busy/done handshake,
// stepping one bit per enabled clock.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [SHAMT_W-1:0] amt,
    input  logic [WIDTH-1:0]   din,
    input  logic               ser_in,
    output logic [WIDTH-1:0]   dout,
    output logic               ser_out,
    output logic               busy,
    output logic               done
);

    state_t             state;
    state_t             state_nx;
    logic [2:0]         mode_q;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   data_q;
    logic               ser_q;
    logic [WIDTH-1:0]   step_data;
    logic               step_bit;

    shift_step_unit #(
        .WIDTH(WIDTH)
    ) u_step (
        .data     (data_q),
        .mode     (mode_q),
        .ser_in   (ser_in),
        .next_data(step_data),
        .out_bit  (step_bit)
    );

    // State register; a disabled clock freezes the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (en) begin
            state <= state_nx;
        end
    end

    // Next-state: loads and zero-length shifts go straight to DONE.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (!is_shift_mode(mode) || amt == '0) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (cnt == SHAMT_W'(1)) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decode directly from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: capture the command in IDLE, apply one step per SHIFT edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            ser_q  <= 1'b0;
            cnt    <= '0;
            mode_q <= MODE_LOAD;
        end else if (en) begin
            if (state == ST_IDLE && start) begin
                data_q <= din;
                mode_q <= mode;
                cnt    <= amt;
            end else if (state == ST_SHIFT) begin
                data_q <= step_data;
                ser_q  <= step_bit;
                cnt    <= cnt - SHAMT_W'(1);
            end
        end
    end

    assign dout    = data_q;
    assign ser_out = ser_q;

endmodule
